triangle_setup: RTL and testbench

- Sits directly downstream of the geometry engine's viewport-map stage.
- Accepts screen-space vertices (Q16.16) one at a time and groups every 3 consecutive vertices into a triangle.
- Computes clamped bounding box, three edge-function coefficients and twice the signed area, then culls back-facing, degenerate, dropped or fully off-screen triangles.
- Hands surviving triangles to the rasterizer over a valid/ready handshake.

---
 rtl/triangle_setup.sv | 147 ++++++++++++++
 tb/tb_triangle_setup.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_setup.sv
// Triangle setup: gathers three screen-space vertices, derives edge equations,
// doubled area and clamped bbox, culls, then offers the triangle to the rasterizer.
module triangle_setup #(
    parameter int SCREEN_W      = 320,
    parameter int SCREEN_H      = 240,
    parameter bit CULL_BACKFACE = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vtx_valid,
    output logic        o_vtx_ready,
    input  logic [31:0] i_vtx_x,
    input  logic [31:0] i_vtx_y,
    input  logic        i_vtx_drop,
    output logic        o_tri_valid,
    input  logic        i_tri_ready,
    output logic [15:0] o_bbox_xmin,
    output logic [15:0] o_bbox_xmax,
    output logic [15:0] o_bbox_ymin,
    output logic [15:0] o_bbox_ymax,
    output logic [50:0] o_edge_a,
    output logic [50:0] o_edge_b,
    output logic [98:0] o_edge_c,
    output logic [34:0] o_area2,
    output logic [15:0] o_cull_count
);
    localparam logic signed [15:0] XLIM = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] YLIM = 16'(SCREEN_H - 1);

    typedef enum logic [2:0] {S_V0, S_V1, S_V2, S_SETUP1, S_SETUP2, S_OUT} state_t;
    state_t state, state_nxt;

    logic signed [15:0] vx [3];
    logic signed [15:0] vy [3];
    logic               drop_any;
    logic               vtx_fire;
    logic [1:0]         slot;
    logic signed [15:0] xmin, xmax, ymin, ymax;
    logic signed [15:0] xmin_c, xmax_c, ymin_c, ymax_c;
    logic [2:0][16:0]   edge_a, edge_b;
    logic [2:0][32:0]   edge_c;
    logic signed [34:0] area2;
    logic               cull;
    logic               unused_frac;

    // Only the integer pixel part matters; fractions are truncated away.
    assign unused_frac = ^{i_vtx_x[15:0], i_vtx_y[15:0]};

    function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_edge
        localparam int K1 = (k + 1) % 3;
        logic signed [31:0] p_fwd, p_rev;
        assign p_fwd     = vx[k] * vy[K1];
        assign p_rev     = vx[K1] * vy[k];
        assign edge_a[k] = {vy[k][15], vy[k]} - {vy[K1][15], vy[K1]};
        assign edge_b[k] = {vx[K1][15], vx[K1]} - {vx[k][15], vx[k]};
        assign edge_c[k] = {p_fwd[31], p_fwd} - {p_rev[31], p_rev};
    end

    assign area2 = {{2{edge_c[0][32]}}, edge_c[0]} + {{2{edge_c[1][32]}}, edge_c[1]}
                 + {{2{edge_c[2][32]}}, edge_c[2]};

    assign xmin_c = xmin[15] ? 16'sd0 : xmin;
    assign ymin_c = ymin[15] ? 16'sd0 : ymin;
    assign xmax_c = (xmax > XLIM) ? XLIM : xmax;
    assign ymax_c = (ymax > YLIM) ? YLIM : ymax;

    // A bbox that collapses after clamping means nothing lands on screen.
    assign cull = drop_any || (area2 == 35'sd0) || (CULL_BACKFACE && area2[34])
               || (xmin_c > xmax_c) || (ymin_c > ymax_c);

    assign vtx_fire = i_vtx_valid && o_vtx_ready;

    always_comb begin
        state_nxt   = state;
        o_vtx_ready = 1'b0;
        o_tri_valid = 1'b0;
        slot        = 2'd0;
        case (state)
            S_V0:     begin o_vtx_ready = 1'b1; slot = 2'd0; if (i_vtx_valid) state_nxt = S_V1; end
            S_V1:     begin o_vtx_ready = 1'b1; slot = 2'd1; if (i_vtx_valid) state_nxt = S_V2; end
            S_V2:     begin o_vtx_ready = 1'b1; slot = 2'd2; if (i_vtx_valid) state_nxt = S_SETUP1; end
            S_SETUP1: state_nxt = S_SETUP2;
            S_SETUP2: state_nxt = cull ? S_V0 : S_OUT;
            S_OUT:    begin o_tri_valid = 1'b1; if (i_tri_ready) state_nxt = S_V0; end
            default:  state_nxt = S_V0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_V0;
            vx           <= '{default: '0};
            vy           <= '{default: '0};
            drop_any     <= 1'b0;
            xmin         <= '0;
            xmax         <= '0;
            ymin         <= '0;
            ymax         <= '0;
            o_bbox_xmin  <= '0;
            o_bbox_xmax  <= '0;
            o_bbox_ymin  <= '0;
            o_bbox_ymax  <= '0;
            o_edge_a     <= '0;
            o_edge_b     <= '0;
            o_edge_c     <= '0;
            o_area2      <= '0;
            o_cull_count <= '0;
        end else begin
            state <= state_nxt;
            if (vtx_fire) begin
                vx[slot] <= i_vtx_x[31:16];
                vy[slot] <= i_vtx_y[31:16];
                drop_any <= (state == S_V0) ? i_vtx_drop : (drop_any | i_vtx_drop);
            end
            if (state == S_SETUP1) begin
                o_edge_a <= edge_a;
                o_edge_b <= edge_b;
                xmin     <= min3(vx[0], vx[1], vx[2]);
                xmax     <= max3(vx[0], vx[1], vx[2]);
                ymin     <= min3(vy[0], vy[1], vy[2]);
                ymax     <= max3(vy[0], vy[1], vy[2]);
            end
            if (state == S_SETUP2) begin
                o_edge_c    <= edge_c;
                o_area2     <= area2;
                o_bbox_xmin <= xmin_c;
                o_bbox_xmax <= xmax_c;
                o_bbox_ymin <= ymin_c;
                o_bbox_ymax <= ymax_c;
                if (cull && o_cull_count != 16'hFFFF)
                    o_cull_count <= o_cull_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: hand-computed triangles, culling, stall,
// mid-triangle reset and cull-counter saturation.
module tb_triangle_setup;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        vv = 1'b0, drop = 1'b0, tr = 1'b0;
    logic [31:0] vx = '0, vy = '0;

    logic        rdy1, tv1, rdy2, tv2;
    logic [15:0] xmin1, xmax1, ymin1, ymax1, xmin2, xmax2, ymin2, ymax2;
    logic [50:0] ea1, eb1, ea2, eb2;
    logic [98:0] ec1, ec2;
    logic [34:0] ar1, ar2;
    logic [15:0] cnt1, cnt2;

    triangle_setup #(.SCREEN_W(320), .SCREEN_H(240), .CULL_BACKFACE(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_vtx_valid(vv & ~sel), .o_vtx_ready(rdy1),
        .i_vtx_x(vx), .i_vtx_y(vy), .i_vtx_drop(drop), .o_tri_valid(tv1),
        .i_tri_ready(tr & ~sel), .o_bbox_xmin(xmin1), .o_bbox_xmax(xmax1),
        .o_bbox_ymin(ymin1), .o_bbox_ymax(ymax1), .o_edge_a(ea1), .o_edge_b(eb1),
        .o_edge_c(ec1), .o_area2(ar1), .o_cull_count(cnt1)
    );

    triangle_setup #(.SCREEN_W(320), .SCREEN_H(240), .CULL_BACKFACE(1'b0)) dut_nb (
        .i_clk(clk), .i_rst(rst), .i_vtx_valid(vv & sel), .o_vtx_ready(rdy2),
        .i_vtx_x(vx), .i_vtx_y(vy), .i_vtx_drop(drop), .o_tri_valid(tv2),
        .i_tri_ready(tr & sel), .o_bbox_xmin(xmin2), .o_bbox_xmax(xmax2),
        .o_bbox_ymin(ymin2), .o_bbox_ymax(ymax2), .o_edge_a(ea2), .o_edge_b(eb2),
        .o_edge_c(ec2), .o_area2(ar2), .o_cull_count(cnt2)
    );

    wire        rdy = sel ? rdy2 : rdy1;
    wire        tv  = sel ? tv2 : tv1;
    wire [34:0] ar  = sel ? ar2 : ar1;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int passed = 0;
    int total  = 0;

    // Fraction bits are nonzero so truncation of the Q16.16 input is exercised.
    task automatic send_vtx(input int x, input int y, input logic d, output int n);
        vv   = 1'b1;
        vx   = {x[15:0], 16'hABCD};
        vy   = {y[15:0], 16'h4321};
        drop = d;
        for (int t = 0; t < 20 && !rdy; t++) @(negedge clk);
        if (!rdy) begin
            total++;
            $display("FAIL vtx_accept: ready never rose (got 0, want 1)");
        end
        n = cyc;
        @(negedge clk);
        vv   = 1'b0;
        drop = 1'b0;
    endtask

    task automatic send_tri(input int x0, y0, x1, y1, x2, y2,
                            input logic d0, d1, d2, output int n);
        int m;
        send_vtx(x0, y0, d0, m);
        send_vtx(x1, y1, d1, m);
        send_vtx(x2, y2, d2, n);
    endtask

    task automatic wait_valid(output int c);
        c = -1;
        for (int t = 0; t < 12; t++) begin
            if (tv) begin c = cyc; break; end
            @(negedge clk);
        end
    endtask

    // Watches the four cycles after a third vertex; reports any valid and ready rise.
    task automatic observe_cull(output logic seen, output int rdy_at);
        seen = 1'b0; rdy_at = -1;
        for (int t = 0; t < 4; t++) begin
            if (tv) seen = 1'b1;
            if (rdy && rdy_at < 0) rdy_at = cyc;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (tv1 !== 1'b0) $display("FAIL reset_valid: got %0b want 0", tv1); else passed++;
        total++; if (rdy1 !== 1'b1) $display("FAIL reset_ready: got %0b want 1", rdy1); else passed++;
        total++; if (ar1 !== 35'd0 || ea1 !== 51'd0 || eb1 !== 51'd0 || ec1 !== 99'd0)
            $display("FAIL reset_edges: area2=%0h a=%0h b=%0h c=%0h want 0", ar1, ea1, eb1, ec1);
        else passed++;
        total++; if ({xmin1, xmax1, ymin1, ymax1, cnt1} !== 80'd0)
            $display("FAIL reset_bbox_cnt: got %0h want 0", {xmin1, xmax1, ymin1, ymax1, cnt1});
        else passed++;
    endtask

    task automatic test_basic;
        int n, c;
        logic [50:0] ea, eb;
        logic [98:0] ec;
        ea = {17'sd40, -17'sd40, 17'sd0};
        eb = {17'sd0, -17'sd40, 17'sd40};
        ec = {-33'sd400, 33'sd2400, -33'sd400};
        tr = 1'b1;
        send_tri(10, 10, 50, 10, 10, 50, 0, 0, 0, n);
        wait_valid(c);
        total++; if (c !== n + 3) $display("FAIL basic_latency: got %0d want %0d", c, n + 3); else passed++;
        total++; if (ar1 !== 35'sd1600) $display("FAIL basic_area2: got %0d want 1600", $signed(ar1)); else passed++;
        total++; if (ea1 !== ea) $display("FAIL basic_edge_a: got %0h want %0h", ea1, ea); else passed++;
        total++; if (eb1 !== eb) $display("FAIL basic_edge_b: got %0h want %0h", eb1, eb); else passed++;
        total++; if (ec1 !== ec) $display("FAIL basic_edge_c: got %0h want %0h", ec1, ec); else passed++;
        total++; if ({xmin1, xmax1, ymin1, ymax1} !== {16'd10, 16'd50, 16'd10, 16'd50})
            $display("FAIL basic_bbox: got %0d..%0d %0d..%0d want 10..50 10..50", xmin1, xmax1, ymin1, ymax1);
        else passed++;
        @(negedge clk);
        total++; if (tv1 !== 1'b0 || rdy1 !== 1'b1)
            $display("FAIL basic_after: valid=%0b ready=%0b want 0 1", tv1, rdy1);
        else passed++;
    endtask

    task automatic test_backface;
        int n, c, rdy_at;
        logic seen;
        send_tri(10, 10, 10, 50, 50, 10, 0, 0, 0, n);
        observe_cull(seen, rdy_at);
        total++; if (seen !== 1'b0) $display("FAIL backface_emit: got valid 1 want 0"); else passed++;
        total++; if (cnt1 !== 16'd1) $display("FAIL backface_count: got %0d want 1", cnt1); else passed++;
        total++; if (rdy_at !== n + 3) $display("FAIL backface_ready: got %0d want %0d", rdy_at, n + 3); else passed++;
        sel = 1'b1;
        send_tri(10, 10, 10, 50, 50, 10, 0, 0, 0, n);
        wait_valid(c);
        total++; if (c !== n + 3) $display("FAIL nocull_latency: got %0d want %0d", c, n + 3); else passed++;
        total++; if (ar !== -35'sd1600) $display("FAIL nocull_area2: got %0d want -1600", $signed(ar)); else passed++;
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_clamp;
        int n, c, rdy_at;
        logic seen;
        send_tri(-20, -20, 400, -20, -20, 300, 0, 0, 0, n);
        wait_valid(c);
        total++; if (c !== n + 3 || ar1 !== 35'sd134400)
            $display("FAIL clamp_area2: cyc %0d area %0d want cyc %0d area 134400", c, $signed(ar1), n + 3);
        else passed++;
        total++; if ({xmin1, xmax1, ymin1, ymax1} !== {16'd0, 16'd319, 16'd0, 16'd239})
            $display("FAIL clamp_bbox: got %0d..%0d %0d..%0d want 0..319 0..239", xmin1, xmax1, ymin1, ymax1);
        else passed++;
        @(negedge clk);
        send_tri(400, 10, 500, 10, 400, 50, 0, 0, 0, n);
        observe_cull(seen, rdy_at);
        total++; if (seen !== 1'b0 || cnt1 !== 16'd2)
            $display("FAIL offscreen_cull: valid %0b count %0d want 0 2", seen, cnt1);
        else passed++;
    endtask

    task automatic test_degenerate_drop;
        int n, rdy_at;
        logic seen;
        send_tri(0, 0, 10, 10, 20, 20, 0, 0, 0, n);
        observe_cull(seen, rdy_at);
        total++; if (seen !== 1'b0 || cnt1 !== 16'd3)
            $display("FAIL collinear_cull: valid %0b count %0d want 0 3", seen, cnt1);
        else passed++;
        send_tri(10, 10, 50, 10, 10, 50, 0, 1, 0, n);
        observe_cull(seen, rdy_at);
        total++; if (seen !== 1'b0 || cnt1 !== 16'd4)
            $display("FAIL drop_cull: valid %0b count %0d want 0 4", seen, cnt1);
        else passed++;
    endtask

    task automatic test_stall;
        int n, c;
        tr = 1'b0;
        send_tri(10, 10, 50, 10, 10, 50, 0, 0, 0, n);
        wait_valid(c);
        total++; if (c !== n + 3) $display("FAIL stall_latency: got %0d want %0d", c, n + 3); else passed++;
        vv = 1'b1; vx = {16'd7, 16'd0}; vy = {16'd3, 16'd0};
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            total++;
            if (tv1 !== 1'b1 || rdy1 !== 1'b0 || ar1 !== 35'sd1600 || xmax1 !== 16'd50)
                $display("FAIL stall_hold: valid %0b ready %0b area %0d xmax %0d want 1 0 1600 50",
                         tv1, rdy1, $signed(ar1), xmax1);
            else passed++;
        end
        tr = 1'b1;
        @(negedge clk);
        vv = 1'b0;
        total++; if (tv1 !== 1'b0 || rdy1 !== 1'b1)
            $display("FAIL stall_release: valid %0b ready %0b want 0 1", tv1, rdy1);
        else passed++;
        send_tri(0, 0, 100, 0, 0, 100, 0, 0, 0, n);
        wait_valid(c);
        total++; if (c !== n + 3 || ar1 !== 35'sd10000)
            $display("FAIL stall_next: cyc %0d area %0d want cyc %0d area 10000", c, $signed(ar1), n + 3);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n, c;
        send_vtx(100, 100, 0, n);
        send_vtx(200, 150, 0, n);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (rdy1 !== 1'b1 || tv1 !== 1'b0 || cnt1 !== 16'd0)
            $display("FAIL midreset_state: ready %0b valid %0b count %0d want 1 0 0", rdy1, tv1, cnt1);
        else passed++;
        send_tri(10, 10, 50, 10, 10, 50, 0, 0, 0, n);
        wait_valid(c);
        total++; if (c !== n + 3 || ar1 !== 35'sd1600)
            $display("FAIL midreset_tri: cyc %0d area %0d want cyc %0d area 1600", c, $signed(ar1), n + 3);
        else passed++;
        @(negedge clk);
    endtask

    // Continuous dropped vertices cull one triangle every 5 cycles.
    task automatic test_saturate;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vv = 1'b1; drop = 1'b1; vx = '0; vy = '0;
        repeat (65534 * 5) @(posedge clk);
        @(negedge clk);
        total++; if (cnt1 !== 16'hFFFE) $display("FAIL sat_pre: got %0h want fffe", cnt1); else passed++;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++; if (cnt1 !== 16'hFFFF) $display("FAIL sat_hit: got %0h want ffff", cnt1); else passed++;
        repeat (25) @(posedge clk);
        @(negedge clk);
        total++; if (cnt1 !== 16'hFFFF) $display("FAIL sat_hold: got %0h want ffff", cnt1); else passed++;
        vv = 1'b0; drop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backface();
        test_clamp();
        test_degenerate_drop();
        test_stall();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
